// File: rtl/motor_pwm_drive.sv
// Two-channel DC motor drive: glitch filter, soft-start/stop duty ramp and PWM comparator per channel.
// Define MOTOR_RAMP_EN to ramp duty by RAMP_STEP per PWM period; otherwise duty jumps between 0 and DUTY_MAX.
module motor_pwm_drive #(
    parameter int PWM_BITS    = 8,
    parameter int DUTY_MAX    = 200,
    parameter int RAMP_STEP   = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic left,
    input  logic right,
    output logic pwm_left,
    output logic pwm_right,
    output logic moving_left,
    output logic moving_right,
    output logic at_speed_left,
    output logic at_speed_right
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef MOTOR_RAMP_EN
    localparam int STEP = RAMP_STEP;
`else
    localparam int STEP = DUTY_MAX;
`endif
    localparam logic [PWM_BITS:0]   STEP_X    = (PWM_BITS + 1)'(STEP);
    localparam logic [PWM_BITS:0]   MAX_X     = (PWM_BITS + 1)'(DUTY_MAX);
    localparam logic [PWM_BITS-1:0] DUTY_TOP  = PWM_BITS'(DUTY_MAX);
    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_RUN,
        ST_DOWN
    } state_e;

    // Index 0 is the left channel, index 1 the right channel.
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          raw;
    logic [1:0]          cmd_q, cmd_d;
    logic [CNT_W-1:0]    hold_q  [2];
    logic [CNT_W-1:0]    hold_d  [2];
    logic [PWM_BITS-1:0] duty_q  [2];
    logic [PWM_BITS-1:0] duty_d  [2];
    state_e              state_q [2];
    state_e              state_d [2];
    logic                boundary;

    // Sums are one bit wider than the duty so the saturation compare never sees a wrapped value.
    function automatic logic [PWM_BITS-1:0] ramp_up(input logic [PWM_BITS-1:0] duty);
        logic [PWM_BITS:0] sum;
        sum = {1'b0, duty} + STEP_X;
        return (sum >= MAX_X) ? DUTY_TOP : sum[PWM_BITS-1:0];
    endfunction

    function automatic logic [PWM_BITS-1:0] ramp_down(input logic [PWM_BITS-1:0] duty);
        logic [PWM_BITS:0] diff;
        diff = {1'b0, duty} - STEP_X;
        return ({1'b0, duty} <= STEP_X) ? '0 : diff[PWM_BITS-1:0];
    endfunction

    assign raw      = {right, left};
    assign boundary = (cnt_q == '1);
    assign cnt_d    = cnt_q + 1'b1;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        cmd_d   = cmd_q;
        hold_d  = hold_q;
        state_d = state_q;
        duty_d  = duty_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (raw[ch] == cmd_q[ch]) begin
                hold_d[ch] = '0;
            end else if (hold_q[ch] == HOLD_LAST) begin
                cmd_d[ch]  = raw[ch];
                hold_d[ch] = '0;
            end else begin
                hold_d[ch] = hold_q[ch] + 1'b1;
            end

            // A command flip always beats the duty step; the new direction steps at the next boundary.
            case (state_q[ch])
                ST_IDLE: if (cmd_q[ch]) state_d[ch] = ST_UP;
                ST_UP: begin
                    if (!cmd_q[ch]) begin
                        state_d[ch] = ST_DOWN;
                    end else if (boundary) begin
                        duty_d[ch] = ramp_up(duty_q[ch]);
                        if (ramp_up(duty_q[ch]) == DUTY_TOP) state_d[ch] = ST_RUN;
                    end
                end
                ST_RUN: if (!cmd_q[ch]) state_d[ch] = ST_DOWN;
                ST_DOWN: begin
                    if (cmd_q[ch]) begin
                        state_d[ch] = ST_UP;
                    end else if (boundary) begin
                        duty_d[ch] = ramp_down(duty_q[ch]);
                        if (ramp_down(duty_q[ch]) == '0) state_d[ch] = ST_IDLE;
                    end
                end
                default: state_d[ch] = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            cmd_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                hold_q[ch]  <= '0;
                duty_q[ch]  <= '0;
                state_q[ch] <= ST_IDLE;
            end
        end else begin
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            hold_q  <= hold_d;
            duty_q  <= duty_d;
            state_q <= state_d;
        end
    end

    assign pwm_left       = (cnt_q < duty_q[0]);
    assign pwm_right      = (cnt_q < duty_q[1]);
    assign moving_left    = (state_q[0] != ST_IDLE);
    assign moving_right   = (state_q[1] != ST_IDLE);
    assign at_speed_left  = (state_q[0] == ST_RUN);
    assign at_speed_right = (state_q[1] == ST_RUN);

endmodule

// File: tb/tb_motor_pwm_drive.sv
// Self-checking bench for motor_pwm_drive: directed scenarios then random commands, every cycle
// compared against an arithmetic model of filter, ramp and PWM (honours MOTOR_RAMP_EN like the DUT).
module tb_motor_pwm_drive;

    localparam int PB     = 4;
    localparam int DMAX   = 12;
    localparam int RSTEP  = 4;
    localparam int HOLD   = 4;
    localparam int PERIOD = 1 << PB;
`ifdef MOTOR_RAMP_EN
    localparam int STEP_M = RSTEP;
`else
    localparam int STEP_M = DMAX;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic left  = 1'b0;
    logic right = 1'b0;
    logic pwm_left, pwm_right, moving_left, moving_right, at_speed_left, at_speed_right;

    int n_checks = 0;
    int n_errors = 0;

    // Model: accepted command, direction the channel is heading, duty, and whether it rests on a rail.
    int            m_cnt;
    int            m_duty    [2];
    bit            m_dir     [2];
    bit            m_settled [2];
    bit            m_cmd     [2];
    logic [HOLD-1:0] m_hist  [2];

    motor_pwm_drive #(
        .PWM_BITS   (PB),
        .DUTY_MAX   (DMAX),
        .RAMP_STEP  (RSTEP),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .left          (left),
        .right         (right),
        .pwm_left      (pwm_left),
        .pwm_right     (pwm_right),
        .moving_left   (moving_left),
        .moving_right  (moving_right),
        .at_speed_left (at_speed_left),
        .at_speed_right(at_speed_right)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_duty[ch]    = 0;
            m_dir[ch]     = 1'b0;
            m_settled[ch] = 1'b1;
            m_cmd[ch]     = 1'b0;
            m_hist[ch]    = '0;
        end
    endtask

    // One rising edge of the reference: uses the command accepted before this edge,
    // then folds the newly sampled raw input into the history window.
    task automatic model_edge();
        bit raw [2];
        bit bnd;
        if (!rst_n) begin
            model_reset();
        end else begin
            raw[0] = left;
            raw[1] = right;
            bnd    = (m_cnt == PERIOD - 1);
            m_cnt  = (m_cnt + 1) % PERIOD;
            for (int ch = 0; ch < 2; ch++) begin
                if (m_cmd[ch] != m_dir[ch]) begin
                    m_dir[ch]     = m_cmd[ch];
                    m_settled[ch] = 1'b0;
                end else if (bnd) begin
                    if (m_dir[ch]) begin
                        m_duty[ch]    = (m_duty[ch] + STEP_M > DMAX) ? DMAX : m_duty[ch] + STEP_M;
                        m_settled[ch] = (m_duty[ch] == DMAX);
                    end else begin
                        m_duty[ch]    = (m_duty[ch] - STEP_M < 0) ? 0 : m_duty[ch] - STEP_M;
                        m_settled[ch] = (m_duty[ch] == 0);
                    end
                end
                m_hist[ch] = {m_hist[ch][HOLD-2:0], raw[ch]};
                if (m_hist[ch] == {HOLD{~m_cmd[ch]}}) m_cmd[ch] = raw[ch];
            end
        end
    endtask

    task automatic check_outputs(input string phase);
        chk({phase, ":pwm_left"},       pwm_left,       m_cnt < m_duty[0]);
        chk({phase, ":pwm_right"},      pwm_right,      m_cnt < m_duty[1]);
        chk({phase, ":moving_left"},    moving_left,    !(!m_dir[0] && m_settled[0]));
        chk({phase, ":moving_right"},   moving_right,   !(!m_dir[1] && m_settled[1]));
        chk({phase, ":at_speed_left"},  at_speed_left,  m_dir[0] && m_settled[0]);
        chk({phase, ":at_speed_right"}, at_speed_right, m_dir[1] && m_settled[1]);
    endtask

    task automatic tick(input string phase);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(phase);
    endtask

    task automatic run(input string phase, input int n);
        for (int i = 0; i < n; i++) tick(phase);
    endtask

    initial begin
        model_reset();

        // Reset: outputs idle while held and on the first cycle after release.
        run("reset", 3);
        rst_n = 1'b1;
        tick("release");

        // Spin-up and steady run of the left channel.
        left = 1'b1;
        run("spinup", 4 * PERIOD + 8);

        // Spin-down back to idle.
        left = 1'b0;
        run("spindown", 4 * PERIOD + 8);

        // 3-cycle glitch must be rejected.
        left = 1'b1;
        run("glitch_hi", 3);
        left = 1'b0;
        run("glitch_lo", PERIOD + 4);

        // Reversal mid-ramp: drop the command at duty 8 going up, re-raise at duty 4 going down.
        left = 1'b1;
        for (int i = 0; i < 6 * PERIOD && !(m_dir[0] && m_duty[0] == 8); i++) tick("rev_up");
        left = 1'b0;
        for (int i = 0; i < 6 * PERIOD && !(!m_dir[0] && m_duty[0] == 4); i++) tick("rev_down");
        left = 1'b1;
        run("rev_reup", 4 * PERIOD);

        // Both channels at speed, then asynchronous reset in mid-cycle.
        right = 1'b1;
        run("both_run", 5 * PERIOD);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        run("in_reset", 2);
        #3;
        rst_n = 1'b1;
        run("restart", 4 * PERIOD);

        // Right channel alone from idle.
        left  = 1'b0;
        right = 1'b0;
        run("settle", 5 * PERIOD);
        right = 1'b1;
        run("right_up", 3 * PERIOD);

        // Random command patterns of varying length, including sub-hold glitches.
        for (int seg = 0; seg < 300; seg++) begin
            left  = 1'($urandom_range(0, 1));
            right = 1'($urandom_range(0, 1));
            run("random", int'($urandom_range(1, 40)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
